// File: rtl/tx_shaping_filter.sv
// -----------------------------------------------------------------------------
// tx_shaping_filter
//
// Oversampled I/Q transmit pulse-shaping FIR. Binary symbols (0 -> +1,
// 1 -> -1) are held in per-rail shift registers; on each sample-rate enable a
// polyphase sum is formed by adding or subtracting the taps selected by the
// current phase. This makes the filter multiplier-free. The result is
// aligned, saturated and registered.
//
// Ports:
//   clk         - sole clock, rising edge
//   i_reset     - synchronous active-high reset
//   i_en        - sample-rate enable, one output sample per asserted cycle
//   i_symb_I/Q  - symbol bits (0 -> +1, 1 -> -1), consumed when o_symb_req
//   i_coef      - NUM_TAPS packed signed taps S(NBT_COEF,NBF_COEF), tap k at
//                 bits [(k+1)*NBT_COEF-1 : k*NBT_COEF], shared by both rails
//   o_symb_req  - combinational, high in the cycle a symbol is consumed
//   o_data_I/Q  - shaped samples S(NBT_OUT,NBF_OUT)
//   o_valid     - o_data_I/Q hold a new sample (2 clocks after i_en)
// -----------------------------------------------------------------------------
module tx_shaping_filter #(
  parameter  int OS       = 4,
  parameter  int NUM_SYMB = 6,
  parameter  int NBT_COEF = 8,
  parameter  int NBF_COEF = 7,
  parameter  int NBT_OUT  = 8,
  parameter  int NBF_OUT  = 7,
  localparam int NUM_TAPS = OS * NUM_SYMB
) (
  input  logic                               clk,
  input  logic                               i_reset,
  input  logic                               i_en,
  input  logic                               i_symb_I,
  input  logic                               i_symb_Q,
  input  logic [NUM_TAPS*NBT_COEF-1:0]       i_coef,
  output logic                               o_symb_req,
  output logic signed [NBT_OUT-1:0]          o_data_I,
  output logic signed [NBT_OUT-1:0]          o_data_Q,
  output logic                               o_valid
);

  localparam int ACC_W = NBT_COEF + $clog2(NUM_SYMB);
  localparam int PH_W  = (OS > 1) ? $clog2(OS) : 1;
  localparam int IDX_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  // Fraction bits dropped to align the accumulator to the output format.
  localparam int DROP  = (NBF_COEF > NBF_OUT) ? (NBF_COEF - NBF_OUT) : 0;

  logic [PH_W-1:0]               phase_cnt_r;
  logic [PH_W-1:0]               p_r;
  logic                          v1_r;
  logic [NUM_SYMB-1:0]           sym_i_r;
  logic [NUM_SYMB-1:0]           sym_q_r;
  logic [NUM_SYMB-1:0]           vld_i_r;
  logic [NUM_SYMB-1:0]           vld_q_r;
  logic signed [NBT_COEF-1:0]    tap_a [NUM_TAPS];
  logic signed [ACC_W-1:0]       acc_i_s;
  logic signed [ACC_W-1:0]       acc_q_s;

  // Align to output fraction by truncation, then clamp to the output range.
  function automatic logic [NBT_OUT-1:0] sat_out(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] a;
    logic [ACC_W-NBT_OUT:0]  hi_bits;
    a       = v >>> DROP;
    hi_bits = a[ACC_W-1:NBT_OUT-1];
    if ((&hi_bits) || !(|hi_bits)) begin
      sat_out = a[NBT_OUT-1:0];
    end else if (a[ACC_W-1]) begin
      sat_out = {1'b1, {(NBT_OUT-1){1'b0}}};
    end else begin
      sat_out = {1'b0, {(NBT_OUT-1){1'b1}}};
    end
  endfunction

  // Unpack the flat coefficient bus into an indexable tap array.
  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
    assign tap_a[k] = i_coef[k*NBT_COEF +: NBT_COEF];
  end

  assign o_symb_req = i_en & (phase_cnt_r == {PH_W{1'b0}}) & ~i_reset;

  // Phase counter: advances on every enabled sample, holds during gaps.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      phase_cnt_r <= {PH_W{1'b0}};
    end else if (i_en) begin
      if (phase_cnt_r == PH_W'(OS - 1)) begin
        phase_cnt_r <= {PH_W{1'b0}};
      end else begin
        phase_cnt_r <= phase_cnt_r + PH_W'(1);
      end
    end else begin
      phase_cnt_r <= phase_cnt_r;
    end
  end

  // Symbol history: slot 0 takes the new symbol, the oldest slot falls off.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      sym_i_r <= {NUM_SYMB{1'b0}};
      sym_q_r <= {NUM_SYMB{1'b0}};
      vld_i_r <= {NUM_SYMB{1'b0}};
      vld_q_r <= {NUM_SYMB{1'b0}};
    end else if (o_symb_req) begin
      for (int m = NUM_SYMB - 1; m > 0; m--) begin
        sym_i_r[m] <= sym_i_r[m-1];
        sym_q_r[m] <= sym_q_r[m-1];
        vld_i_r[m] <= vld_i_r[m-1];
        vld_q_r[m] <= vld_q_r[m-1];
      end
      sym_i_r[0] <= i_symb_I;
      sym_q_r[0] <= i_symb_Q;
      vld_i_r[0] <= 1'b1;
      vld_q_r[0] <= 1'b1;
    end else begin
      sym_i_r <= sym_i_r;
      sym_q_r <= sym_q_r;
      vld_i_r <= vld_i_r;
      vld_q_r <= vld_q_r;
    end
  end

  // Stage 1: remember which phase this sample belongs to.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      p_r  <= {PH_W{1'b0}};
      v1_r <= 1'b0;
    end else if (i_en) begin
      p_r  <= phase_cnt_r;
      v1_r <= 1'b1;
    end else begin
      p_r  <= p_r;
      v1_r <= 1'b0;
    end
  end

  // Polyphase sum: each valid slot adds (+1) or subtracts (-1) its tap.
  always_comb begin
    logic [IDX_W-1:0]        idx;
    logic signed [ACC_W-1:0] tap_ext;
    acc_i_s = {ACC_W{1'b0}};
    acc_q_s = {ACC_W{1'b0}};
    idx     = {IDX_W{1'b0}};
    tap_ext = {ACC_W{1'b0}};
    for (int m = 0; m < NUM_SYMB; m++) begin
      idx     = IDX_W'(m * OS) + IDX_W'(p_r);
      tap_ext = ACC_W'(tap_a[idx]);
      if (vld_i_r[m] && sym_i_r[m]) begin
        acc_i_s = acc_i_s - tap_ext;
      end else if (vld_i_r[m]) begin
        acc_i_s = acc_i_s + tap_ext;
      end else begin
        acc_i_s = acc_i_s;
      end
      if (vld_q_r[m] && sym_q_r[m]) begin
        acc_q_s = acc_q_s - tap_ext;
      end else if (vld_q_r[m]) begin
        acc_q_s = acc_q_s + tap_ext;
      end else begin
        acc_q_s = acc_q_s;
      end
    end
  end

  // Stage 2: register the saturated sample; hold data when no new sample.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      o_data_I <= {NBT_OUT{1'b0}};
      o_data_Q <= {NBT_OUT{1'b0}};
      o_valid  <= 1'b0;
    end else begin
      o_valid <= v1_r;
      if (v1_r) begin
        o_data_I <= sat_out(acc_i_s);
        o_data_Q <= sat_out(acc_q_s);
      end else begin
        o_data_I <= o_data_I;
        o_data_Q <= o_data_Q;
      end
    end
  end

endmodule

// File: doc/tx_shaping_filter.md
TX_SHAPING_FILTER -- requirements
Module: tx_shaping_filter

Interface
REQ-001 Parameters SHALL be: OS, default 4, oversampling factor (samples per symbol); NUM_SYMB, default 6, filter span in symbols; NBT_COEF, default 8, coefficient total bits; NBF_COEF, default 7, coefficient fractional bits; NBT_OUT, default 8, output total bits; NBF_OUT, default 7, output fractional bits.
REQ-002 Localparam NUM_TAPS SHALL equal OS*NUM_SYMB (default 24).
REQ-003 Ports SHALL be:
- clk, input, 1, sole clock, all state on rising edge.
- i_reset, input, 1, synchronous active-high reset.
- i_en, input, 1, sample-rate enable; one output sample per asserted cycle.
- i_symb_I, input, 1, I symbol bit; 0 maps to +1, 1 maps to -1.
- i_symb_Q, input, 1, Q symbol bit, same mapping.
- i_coef, input, NUM_TAPS*NBT_COEF, packed signed S(NBT_COEF,NBF_COEF) taps; tap k at bits [(k+1)*NBT_COEF-1 : k*NBT_COEF]; shared by I and Q.
- o_symb_req, output, 1, combinational; high in the cycle i_symb_I/Q is consumed.
- o_data_I, output, NBT_OUT, signed S(NBT_OUT,NBF_OUT) shaped I sample.
- o_data_Q, output, NBT_OUT, signed S(NBT_OUT,NBF_OUT) shaped Q sample.
- o_valid, output, 1, o_data_I/Q hold a new sample.

Function
REQ-004 A phase counter phase_cnt SHALL count 0..OS-1, advance by 1 on each i_en cycle, wrap OS-1 -> 0, and hold when i_en is low.
REQ-005 o_symb_req SHALL equal i_en & (phase_cnt==0) & ~i_reset.
REQ-006 On a cycle with o_symb_req high, per-rail symbol shift registers (NUM_SYMB slots, each a sign bit plus a valid flag) SHALL shift: slot 0 takes the input bit with valid=1; slot m takes slot m-1; slot NUM_SYMB-1 is discarded.
REQ-007 Stage 1, on every i_en cycle: phase register p_r SHALL capture phase_cnt (pre-increment) and v1 SHALL be set to 1; on cycles with i_en low v1 SHALL be 0.
REQ-008 Stage 2, every cycle: when v1=1, o_data_I/Q SHALL capture sat(S) with S = sum over m=0..NUM_SYMB-1 of c(m)*tap[m*OS+p_r], where c(m) = +1 (bit 0), -1 (bit 1), or 0 (slot invalid), using the shift-register state after REQ-006; o_valid SHALL capture v1.
REQ-009 Latency SHALL be 2 clocks: i_en at cycle t -> o_valid high at t+2 with the sample for phase_cnt(t).
REQ-010 When v1=0, o_data_I/Q SHALL hold their previous value.
REQ-011 Arithmetic SHALL be multiplier-free (add/subtract of tap or zero); accumulator width SHALL be NBT_COEF+$clog2(NUM_SYMB) bits (11 default), fraction NBF_COEF.
REQ-012 Output SHALL be aligned to NBF_OUT by dropping LSBs (truncation) when NBF_COEF>NBF_OUT; with defaults no fractional bits are dropped.
REQ-013 Output saturation: integer bits beyond NBT_OUT-NBF_OUT all equal to sign -> pass; otherwise positive overflow -> 0x7F, negative overflow -> 0x80 (defaults).
REQ-014 Gaps in i_en SHALL NOT corrupt phase or symbol alignment; processing resumes exactly where it stopped.
REQ-015 i_coef SHALL be treated as quasi-static; a change takes effect on the next stage-2 computation, with no internal copy.

Reset
REQ-016 While i_reset is high: phase_cnt=0, p_r=0, v1=0, all slot valid flags=0, slot sign bits=0, o_data_I=o_data_Q=0, o_valid=0, o_symb_req=0.
REQ-017 Reset SHALL take precedence over i_en; reset asserted mid-symbol SHALL discard partial phase state, and the first i_en after release SHALL request a symbol.

Verification
REQ-018 Taps tap[k]=k+1 LSB, reset, i_en held high, I bits 0,1,then 0... -> first four o_data_I = 1,2,3,4 LSB; next four = -1+5 = 4 LSB each; o_symb_req every 4th i_en.
REQ-019 All taps 0x7F, 6 consecutive bit-0 symbols -> S=6*127/128 -> o_data_I=0x7F (saturated); all bit-1 -> 0x80.
REQ-020 i_en toggling 1,0,0,1 with tap[k]=k+1 -> o_valid pulses exactly 2 cycles after each i_en; sample sequence identical to continuous i_en.
REQ-021 Reset at phase 2 after 3 symbols -> outputs 0 next cycle; after release first o_valid sample = tap[0] (slot 0 only valid).
REQ-022 Different I/Q bit streams -> o_data_Q matches independent per-rail model sample-for-sample over 200 random symbols.
